// File: rtl/lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// lock_supervisor_if : front-panel / lock-core signal bundle for lock_supervisor
// Revision 1.0
// ============================================================================
interface lock_supervisor_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              btn0_in;
  logic              btn1_in;
  logic              lock_unlock;
  logic              btn0_out;
  logic              btn1_out;
  logic              lock_rst_n;
  logic              door_open;
  logic              locked_out;
  logic              alarm;
  logic [FAIL_W-1:0] fail_cnt;

  modport master (
    output btn0_in, btn1_in, lock_unlock,
    input  btn0_out, btn1_out, lock_rst_n, door_open, locked_out, alarm, fail_cnt
  );

  modport slave (
    input  btn0_in, btn1_in, lock_unlock,
    output btn0_out, btn1_out, lock_rst_n, door_open, locked_out, alarm, fail_cnt
  );
endinterface
`default_nettype wire

// File: rtl/lock_supervisor.sv
`default_nettype none
// ============================================================================
// lock_supervisor : frames button presses into attempts, door-open and lockout
// Revision 1.0
// ============================================================================
module lock_supervisor #(
  parameter int CODE_LEN       = 5,
  parameter int MAX_FAILS      = 3,
  parameter int OPEN_CYCLES    = 100,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int IDLE_TIMEOUT   = 500
) (
  input  wire logic       clk,
  input  wire logic       rst,
  lock_supervisor_if.slave bus
);
  localparam int PRESS_W = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int T_MAX_A = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int T_MAX   = (T_MAX_A > IDLE_TIMEOUT) ? T_MAX_A : IDLE_TIMEOUT;
  localparam int TIMER_W = $clog2(T_MAX + 1);

  localparam logic [PRESS_W-1:0] C_PRESS_LAST = PRESS_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0]  C_FAIL_LAST  = FAIL_W'(MAX_FAILS - 1);
  localparam logic [FAIL_W-1:0]  C_FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [TIMER_W-1:0] C_OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_LOCK_LAST  = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_IDLE_LAST  = TIMER_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PRESS_W-1:0] press_cnt_q, press_cnt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic               lock_rst_n_q, lock_rst_n_d;
  logic               door_open_q, door_open_d;
  logic               locked_out_q, locked_out_d;
  logic               alarm_q, alarm_d;
  logic               valid_press;

  assign valid_press  = bus.btn0_in ^ bus.btn1_in;
  assign bus.btn0_out = bus.btn0_in & ~bus.btn1_in & (state_q == ENTRY);
  assign bus.btn1_out = bus.btn1_in & ~bus.btn0_in & (state_q == ENTRY);

  // One timer serves idle, open and lockout; it is zero on entry to each state.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    timer_d     = timer_q;
    fail_cnt_d  = fail_cnt_q;
    case (state_q)
      CLEAR: begin
        state_d     = ENTRY;
        press_cnt_d = '0;
        timer_d     = '0;
      end
      ENTRY: begin
        if (valid_press) begin
          timer_d = '0;
          if (bus.lock_unlock) begin
            state_d     = OPEN;
            fail_cnt_d  = '0;
            press_cnt_d = '0;
          end else if (press_cnt_q == C_PRESS_LAST) begin
            press_cnt_d = '0;
            if (fail_cnt_q == C_FAIL_LAST) begin
              state_d    = LOCKOUT;
              fail_cnt_d = C_FAIL_MAX;
            end else begin
              state_d    = CLEAR;
              fail_cnt_d = fail_cnt_q + 1'b1;
            end
          end else begin
            press_cnt_d = press_cnt_q + 1'b1;
          end
        end else if (press_cnt_q != '0) begin
          if (timer_q >= C_IDLE_LAST) begin
            state_d     = CLEAR;
            press_cnt_d = '0;
            timer_d     = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      OPEN: begin
        if (timer_q >= C_OPEN_LAST) begin
          state_d = CLEAR;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q >= C_LOCK_LAST) begin
          state_d    = CLEAR;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    lock_rst_n_d = (state_d == ENTRY);
    door_open_d  = (state_d == OPEN);
    locked_out_d = (state_d == LOCKOUT);
    alarm_d      = (state_q == ENTRY) && (state_d == LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      press_cnt_q  <= '0;
      timer_q      <= '0;
      fail_cnt_q   <= '0;
      lock_rst_n_q <= 1'b0;
      door_open_q  <= 1'b0;
      locked_out_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      press_cnt_q  <= press_cnt_d;
      timer_q      <= timer_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_rst_n_q <= lock_rst_n_d;
      door_open_q  <= door_open_d;
      locked_out_q <= locked_out_d;
      alarm_q      <= alarm_d;
    end
  end

  assign bus.lock_rst_n = lock_rst_n_q;
  assign bus.door_open  = door_open_q;
  assign bus.locked_out = locked_out_q;
  assign bus.alarm      = alarm_q;
  assign bus.fail_cnt   = fail_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_lock_supervisor.sv
`default_nettype none
// ============================================================================
// tb_lock_supervisor : directed + random checks of lock_supervisor
// Revision 1.0
// ============================================================================
module tb_lock_supervisor;
  localparam int CODE_LEN       = 5;
  localparam int MAX_FAILS      = 3;
  localparam int OPEN_CYCLES    = 4;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int IDLE_TIMEOUT   = 6;

  localparam int M_CLEAR = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_LOCK  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lock_supervisor_if #(.MAX_FAILS(MAX_FAILS)) bus ();

  lock_supervisor #(
    .CODE_LEN      (CODE_LEN),
    .MAX_FAILS     (MAX_FAILS),
    .OPEN_CYCLES   (OPEN_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .IDLE_TIMEOUT  (IDLE_TIMEOUT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Lock core stand-in: code b1,b1,b0,b1,b0; unlock is combinational on the last press.
  bit code [CODE_LEN] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  int core_pos = 0;
  bit core_ok  = 1'b1;

  always @(posedge clk) begin
    if (bus.lock_rst_n !== 1'b1) begin
      core_pos <= 0;
      core_ok  <= 1'b1;
    end else if (bus.btn0_out || bus.btn1_out) begin
      if (core_pos < CODE_LEN) core_ok <= core_ok && (bus.btn1_out == code[core_pos]);
      core_pos <= core_pos + 1;
    end
  end

  assign bus.lock_unlock = (bus.btn0_out ^ bus.btn1_out) && (core_pos == CODE_LEN - 1) &&
                           core_ok && (bus.btn1_out == code[CODE_LEN-1]);

  // Reference model: attempt kept as a list of presses, timers as countdowns.
  int m_mode   = M_CLEAR;
  int m_fails  = 0;
  int m_idle   = 0;
  int m_remain = 0;
  bit m_alarm  = 1'b0;
  bit m_att [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit attempt_matches();
    if (m_att.size() != CODE_LEN) return 1'b0;
    for (int i = 0; i < CODE_LEN; i++)
      if (m_att[i] != code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update(input bit b0, input bit b1, input bit r);
    m_alarm = 1'b0;
    if (r) begin
      m_mode = M_CLEAR; m_fails = 0; m_idle = 0; m_remain = 0;
      m_att.delete();
      return;
    end
    case (m_mode)
      M_CLEAR: begin
        m_mode = M_ENTRY; m_idle = 0;
        m_att.delete();
      end
      M_ENTRY: begin
        if (b0 ^ b1) begin
          m_att.push_back(b1);
          m_idle = 0;
          if (attempt_matches()) begin
            m_mode = M_OPEN; m_remain = OPEN_CYCLES; m_fails = 0;
          end else if (m_att.size() == CODE_LEN) begin
            if (m_fails + 1 == MAX_FAILS) begin
              m_mode = M_LOCK; m_remain = LOCKOUT_CYCLES; m_fails = MAX_FAILS; m_alarm = 1'b1;
            end else begin
              m_mode = M_CLEAR; m_fails++;
            end
          end
        end else if (m_att.size() > 0) begin
          m_idle++;
          if (m_idle == IDLE_TIMEOUT) m_mode = M_CLEAR;
        end
      end
      M_OPEN: begin
        m_remain--;
        if (m_remain == 0) m_mode = M_CLEAR;
      end
      default: begin
        m_remain--;
        if (m_remain == 0) begin
          m_mode = M_CLEAR; m_fails = 0;
        end
      end
    endcase
  endtask

  task automatic step(input bit b0, input bit b1, input bit r);
    @(negedge clk);
    bus.btn0_in = b0;
    bus.btn1_in = b1;
    rst = r;
    #1;
    chk("btn0_out", bus.btn0_out, 32'(b0 && !b1 && m_mode == M_ENTRY));
    chk("btn1_out", bus.btn1_out, 32'(b1 && !b0 && m_mode == M_ENTRY));
    model_update(b0, b1, r);
    @(posedge clk);
    #1;
    chk("door_open",  bus.door_open,  32'(m_mode == M_OPEN));
    chk("locked_out", bus.locked_out, 32'(m_mode == M_LOCK));
    chk("lock_rst_n", bus.lock_rst_n, 32'(m_mode == M_ENTRY));
    chk("alarm",      bus.alarm,      32'(m_alarm));
    chk("fail_cnt",   bus.fail_cnt,   32'(m_fails));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input bit b, input int gap);
    step(!b, b, 1'b0);
    idle(gap);
  endtask

  task automatic enter_code(input int gap);
    for (int i = 0; i < CODE_LEN; i++) press(code[i], gap);
  endtask

  task automatic wrong_attempt();
    for (int i = 0; i < CODE_LEN; i++) press(1'b0, 0);
    idle(1);
  endtask

  initial begin
    bus.btn0_in = 1'b0;
    bus.btn1_in = 1'b0;

    // 1: correct code, presses two cycles apart
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    enter_code(1);
    idle(OPEN_CYCLES + 2);

    // 2: three failed attempts into lockout, presses ignored while locked out
    wrong_attempt();
    wrong_attempt();
    for (int i = 0; i < CODE_LEN; i++) press(1'b0, 0);
    press(1'b1, 0);
    press(1'b0, 1);
    step(1'b1, 1'b1, 1'b0);
    idle(LOCKOUT_CYCLES + 2);

    // 3: two failures then success clears the count
    wrong_attempt();
    wrong_attempt();
    enter_code(0);
    idle(OPEN_CYCLES + 2);

    // 4: idle abort mid-attempt, then unlock
    wrong_attempt();
    press(1'b1, 0);
    press(1'b1, 0);
    idle(IDLE_TIMEOUT + 1);
    enter_code(0);
    idle(OPEN_CYCLES + 2);

    // 5: simultaneous press mid-attempt is ignored
    press(1'b1, 0);
    press(1'b1, 0);
    step(1'b1, 1'b1, 1'b0);
    press(1'b0, 0);
    press(1'b1, 0);
    press(1'b0, 0);
    idle(OPEN_CYCLES + 2);

    // 6: reset in the 2nd OPEN cycle and in the 3rd LOCKOUT cycle
    enter_code(0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    wrong_attempt();
    wrong_attempt();
    for (int i = 0; i < CODE_LEN; i++) press(1'b0, 0);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // Random traffic: code entries, random attempts, idles, noise, rare resets
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 4))
        0: enter_code($urandom_range(0, 2));
        1: for (int i = 0; i < CODE_LEN; i++) press(1'($urandom_range(0, 1)), $urandom_range(0, 2));
        2: idle($urandom_range(1, 10));
        3: for (int i = 0; i < 6; i++)
             step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        default: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
